video_timing_gen: RTL and testbench

Parametrised raster timing generator, the successor to the fixed Mr. Do counter chain.
- Horizontal and vertical totals, blank windows, sync windows and sync polarity are parameters.
- A pixel clock-enable replaces the dedicated pixel clock.
- Runtime signed screen-position adjustment is applied to the sync pulses, latched only at frame start so a frame never tears.
- Sits between the core clock domain and every video consumer: tilemap and sprite fetch, palette, and the MiSTer scaler.

---
 rtl/vt_pkg.sv | 38 +++
 rtl/vt_axis.sv | 62 ++++++
 rtl/video_timing_gen.sv | 102 ++++++++++
 tb/tb_video_timing_gen.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/vt_pkg.sv
// Shared timing constants and helper functions for the raster timing generator.
package vt_pkg;

    // Default raster: the Mr. Do timing set
    localparam int DEF_H_TOTAL   = 312;
    localparam int DEF_HBL_START = 256;
    localparam int DEF_HBL_END   = 8;
    localparam int DEF_HS_START  = 264;
    localparam int DEF_HS_END    = 304;
    localparam int DEF_V_TOTAL   = 262;
    localparam int DEF_VBL_START = 224;
    localparam int DEF_VBL_END   = 32;
    localparam int DEF_VS_START  = 256;
    localparam int DEF_VS_END    = 258;
    localparam int DEF_VBLS_LEAD = 8;

    // Add a signed offset to a count and fold it back into [0, total).
    // One correction is enough because |adj| < total.
    function automatic int wrap_add(input int count, input int adj, input int total);
        int sum;
        sum = count + adj;
        if (sum < 0) begin
            sum = sum + total;
        end else if (sum >= total) begin
            sum = sum - total;
        end
        return sum;
    endfunction

    // Window [s, e) on a circular axis; s >= e means the window wraps through 0.
    function automatic logic in_window(input int c, input int s, input int e);
        if (s < e) begin
            return (c >= s) && (c < e);
        end
        return (c >= s) || (c < e);
    endfunction

endpackage

// File: rtl/vt_axis.sv
// One raster axis: wrapping counter plus blank, early-blank and sync decodes.
// Flags are decoded from the next count so they line up with the count register.
module vt_axis
    import vt_pkg::*;
#(
    parameter int TOTAL   = DEF_H_TOTAL,
    parameter int W       = $clog2(TOTAL),
    parameter int BLK_S   = DEF_HBL_START,
    parameter int BLK_E   = DEF_HBL_END,
    parameter int EARLY_S = DEF_HBL_START,
    parameter bit POL     = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] sync_s_i,
    input  logic [W-1:0] sync_e_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o,
    output logic         blk_o,
    output logic         blk_n_o,
    output logic         early_o,
    output logic         sync_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         blk_q, blk_n_q, early_q, sync_q;

    // Next count when enabled: wrap at TOTAL-1
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == W'(TOTAL - 1)) begin
            cnt_d = '0;
        end
    end

    assign wrap_o = en_i && (cnt_q == W'(TOTAL - 1));

    // Counter and registered window flags; everything holds while disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            blk_q   <= 1'b1;
            blk_n_q <= 1'b0;
            early_q <= 1'b1;
            sync_q  <= ~POL;
        end else if (en_i) begin
            cnt_q   <= cnt_d;
            blk_q   <= in_window(int'(cnt_d), BLK_S, BLK_E);
            blk_n_q <= !in_window(int'(cnt_d), BLK_S, BLK_E);
            early_q <= in_window(int'(cnt_d), EARLY_S, BLK_E);
            sync_q  <= in_window(int'(cnt_d), int'(sync_s_i), int'(sync_e_i)) ? POL : ~POL;
        end
    end

    assign cnt_o   = cnt_q;
    assign blk_o   = blk_q;
    assign blk_n_o = blk_n_q;
    assign early_o = early_q;
    assign sync_o  = sync_q;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with per-frame sync position adjust.
module video_timing_gen
    import vt_pkg::*;
#(
    parameter int H_TOTAL   = DEF_H_TOTAL,
    parameter int HBL_START = DEF_HBL_START,
    parameter int HBL_END   = DEF_HBL_END,
    parameter int HS_START  = DEF_HS_START,
    parameter int HS_END    = DEF_HS_END,
    parameter int V_TOTAL   = DEF_V_TOTAL,
    parameter int VBL_START = DEF_VBL_START,
    parameter int VBL_END   = DEF_VBL_END,
    parameter int VS_START  = DEF_VS_START,
    parameter int VS_END    = DEF_VS_END,
    parameter int VBLS_LEAD = DEF_VBLS_LEAD,
    parameter bit SYNC_POL  = 1'b0,
    parameter int ADJ_W     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce_pix,
    input  logic signed [ADJ_W-1:0]      h_adj,
    input  logic signed [ADJ_W-1:0]      v_adj,
    output logic [$clog2(H_TOTAL)-1:0]   h,
    output logic [$clog2(V_TOTAL)-1:0]   v,
    output logic                         hbl,
    output logic                         hbl_n,
    output logic                         vbl,
    output logic                         vbl_n,
    output logic                         vbls,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         line_start,
    output logic                         frame_start
);

    localparam int H_W        = $clog2(H_TOTAL);
    localparam int V_W        = $clog2(V_TOTAL);
    localparam int VBLS_START = wrap_add(VBL_START, -VBLS_LEAD, V_TOTAL);

    logic                    h_wrap, frame_wrap;
    logic                    h_early_unused;
    logic signed [ADJ_W-1:0] h_adj_q, h_adj_d, v_adj_q, v_adj_d;
    logic [H_W-1:0]          hs0, hs1;
    logic [V_W-1:0]          vs0, vs1;
    logic                    line_start_q, frame_start_q;

    // Adjust latches take new values only on the wrap to (0,0); the new frame's
    // first decode already sees the new value
    always_comb begin
        h_adj_d = h_adj_q;
        v_adj_d = v_adj_q;
        if (frame_wrap) begin
            h_adj_d = h_adj;
            v_adj_d = v_adj;
        end
    end

    assign hs0 = H_W'(wrap_add(HS_START, int'(h_adj_d), H_TOTAL));
    assign hs1 = H_W'(wrap_add(HS_END,   int'(h_adj_d), H_TOTAL));
    assign vs0 = V_W'(wrap_add(VS_START, int'(v_adj_d), V_TOTAL));
    assign vs1 = V_W'(wrap_add(VS_END,   int'(v_adj_d), V_TOTAL));

    vt_axis #(
        .TOTAL(H_TOTAL), .W(H_W), .BLK_S(HBL_START), .BLK_E(HBL_END),
        .EARLY_S(HBL_START), .POL(SYNC_POL)
    ) u_h (
        .clk(clk), .reset(reset), .en_i(ce_pix),
        .sync_s_i(hs0), .sync_e_i(hs1),
        .cnt_o(h), .wrap_o(h_wrap),
        .blk_o(hbl), .blk_n_o(hbl_n), .early_o(h_early_unused), .sync_o(hsync)
    );

    vt_axis #(
        .TOTAL(V_TOTAL), .W(V_W), .BLK_S(VBL_START), .BLK_E(VBL_END),
        .EARLY_S(VBLS_START), .POL(SYNC_POL)
    ) u_v (
        .clk(clk), .reset(reset), .en_i(h_wrap),
        .sync_s_i(vs0), .sync_e_i(vs1),
        .cnt_o(v), .wrap_o(frame_wrap),
        .blk_o(vbl), .blk_n_o(vbl_n), .early_o(vbls), .sync_o(vsync)
    );

    // Start pulses and adjust latches; pulses drop on any non-enabled clock
    always_ff @(posedge clk) begin
        if (reset) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            h_adj_q       <= '0;
            v_adj_q       <= '0;
        end else begin
            line_start_q  <= h_wrap;
            frame_start_q <= frame_wrap;
            h_adj_q       <= h_adj_d;
            v_adj_q       <= v_adj_d;
        end
    end

    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default raster instance plus a reduced raster instance
// (16 x 12, active-high syncs) for frame-level behaviour.
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Default-parameter instance
    logic              reset_a, ce_a;
    logic signed [3:0] h_adj_a, v_adj_a;
    logic [8:0]        ha, va;
    logic hbl_a, hbl_n_a, vbl_a, vbl_n_a, vbls_a, hs_a, vs_a, ls_a, fs_a;

    video_timing_gen dut_a (
        .clk(clk), .reset(reset_a), .ce_pix(ce_a), .h_adj(h_adj_a), .v_adj(v_adj_a),
        .h(ha), .v(va), .hbl(hbl_a), .hbl_n(hbl_n_a), .vbl(vbl_a), .vbl_n(vbl_n_a),
        .vbls(vbls_a), .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a)
    );

    // Reduced raster: H 16 (blank 12..1, sync 13..14), V 12 (blank 9..1, vbls 7.., sync 10)
    logic              reset_b, ce_b;
    logic signed [3:0] h_adj_b, v_adj_b;
    logic [3:0]        hb, vb;
    logic hbl_b, hbl_n_b, vbl_b, vbl_n_b, vbls_b, hs_b, vs_b, ls_b, fs_b;

    video_timing_gen #(
        .H_TOTAL(16), .HBL_START(12), .HBL_END(2), .HS_START(13), .HS_END(15),
        .V_TOTAL(12), .VBL_START(9), .VBL_END(2), .VS_START(10), .VS_END(11),
        .VBLS_LEAD(2), .SYNC_POL(1'b1), .ADJ_W(4)
    ) dut_b (
        .clk(clk), .reset(reset_b), .ce_pix(ce_b), .h_adj(h_adj_b), .v_adj(v_adj_b),
        .h(hb), .v(vb), .hbl(hbl_b), .hbl_n(hbl_n_b), .vbl(vbl_b), .vbl_n(vbl_n_b),
        .vbls(vbls_b), .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b)
    );

    int hc = 0;
    int vc = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int win(input int c, input int s, input int e);
        if (s < e) return int'((c >= s) && (c < e));
        return int'((c >= s) || (c < e));
    endfunction

    // Step the reduced instance n pulses, checking every output against the
    // given sync edges; switch the adjust inputs at pulse chg_at
    task automatic run_b(input int n, input int hs0, input int hs1, input int vs0, input int vs1,
                         input int chg_at, input int nh, input int nv);
        for (int i = 0; i < n; i++) begin
            if (i == chg_at) begin
                h_adj_b = 4'(nh);
                v_adj_b = 4'(nv);
            end
            @(negedge clk);
            hc = hc + 1;
            if (hc == 16) begin
                hc = 0;
                vc = (vc == 11) ? 0 : vc + 1;
            end
            chk("b_h", int'(hb), hc);
            chk("b_v", int'(vb), vc);
            chk("b_hbl", int'(hbl_b), int'(hc >= 12 || hc < 2));
            chk("b_hbl_n", int'(hbl_n_b), int'(!(hc >= 12 || hc < 2)));
            chk("b_vbl", int'(vbl_b), int'(vc >= 9 || vc < 2));
            chk("b_vbl_n", int'(vbl_n_b), int'(!(vc >= 9 || vc < 2)));
            chk("b_vbls", int'(vbls_b), int'(vc >= 7 || vc < 2));
            chk("b_hsync", int'(hs_b), win(hc, hs0, hs1));
            chk("b_vsync", int'(vs_b), win(vc, vs0, vs1));
            chk("b_line_start", int'(ls_b), int'(hc == 0));
            chk("b_frame_start", int'(fs_b), int'(hc == 0 && vc == 0));
        end
    endtask

    initial begin
        reset_a = 1'b1; ce_a = 1'b1; h_adj_a = '0; v_adj_a = '0;
        reset_b = 1'b1; ce_b = 1'b1; h_adj_b = 4'sd5; v_adj_b = 4'sd3;
        repeat (2) @(negedge clk);

        // Reset state, default instance (active-low syncs idle high)
        chk("a_rst_h", int'(ha), 0);
        chk("a_rst_v", int'(va), 0);
        chk("a_rst_hbl", int'(hbl_a), 1);
        chk("a_rst_hbl_n", int'(hbl_n_a), 0);
        chk("a_rst_vbl", int'(vbl_a), 1);
        chk("a_rst_vbl_n", int'(vbl_n_a), 0);
        chk("a_rst_vbls", int'(vbls_a), 1);
        chk("a_rst_hsync", int'(hs_a), 1);
        chk("a_rst_vsync", int'(vs_a), 1);
        chk("a_rst_ls", int'(ls_a), 0);
        chk("a_rst_fs", int'(fs_a), 0);

        // One full line: h 1..311 then back to 0 with v=1
        reset_a = 1'b0;
        for (int i = 1; i <= 312; i++) begin
            @(negedge clk);
            chk("a_h", int'(ha), i % 312);
            chk("a_v", int'(va), (i == 312) ? 1 : 0);
            chk("a_hbl", int'(hbl_a), int'((i % 312) >= 256 || (i % 312) < 8));
            chk("a_hsync", int'(hs_a), int'(!((i % 312) >= 264 && (i % 312) < 304)));
            chk("a_vbl", int'(vbl_a), 1);
            chk("a_vsync", int'(vs_a), 1);
            chk("a_line_start", int'(ls_a), int'(i == 312));
            chk("a_frame_start", int'(fs_a), 0);
        end

        // Run to h=311 on line 1, then enable once every 4 clocks
        repeat (311) @(negedge clk);
        chk("a_pre_gate_h", int'(ha), 311);
        for (int k = 0; k < 8; k++) begin
            ce_a = (k % 4 == 0);
            @(negedge clk);
            chk("a_gate_h", int'(ha), (k < 4) ? 0 : 1);
            chk("a_gate_v", int'(va), 2);
            chk("a_gate_ls", int'(ls_a), int'(k == 0));
            chk("a_gate_hbl", int'(hbl_a), 1);
        end

        // Mid-line reset at h=150 on line 2
        ce_a = 1'b1;
        repeat (149) @(negedge clk);
        chk("a_mid_h", int'(ha), 150);
        chk("a_mid_hbl", int'(hbl_a), 0);
        reset_a = 1'b1;
        @(negedge clk);
        chk("a_mrst_h", int'(ha), 0);
        chk("a_mrst_v", int'(va), 0);
        chk("a_mrst_hbl", int'(hbl_a), 1);
        chk("a_mrst_vbl", int'(vbl_a), 1);
        chk("a_mrst_hsync", int'(hs_a), 1);
        chk("a_mrst_vsync", int'(vs_a), 1);
        reset_a = 1'b0;
        ce_a = 1'b0;

        // Reduced instance: reset state with adjust inputs non-zero
        chk("b_rst_h", int'(hb), 0);
        chk("b_rst_hbl", int'(hbl_b), 1);
        chk("b_rst_vbls", int'(vbls_b), 1);
        chk("b_rst_hsync", int'(hs_b), 0);
        chk("b_rst_vsync", int'(vs_b), 0);
        reset_b = 1'b0;
        hc = 0; vc = 0;

        // Frame 0 nominal (latches cleared); change to -4/-3 mid-frame
        run_b(192, 13, 15, 10, 11, 96, -4, -3);
        // Frame 1 shifted; hsync 9..10, vsync line 7; next +1/+1
        run_b(192, 9, 11, 7, 8, 96, 1, 1);
        // Frame 2: hs1 and vs1 wrap to 0: hsync 14..15, vsync line 11
        run_b(192, 14, 0, 11, 0, 96, 1, 1);
        // Into frame 3 up to h=7, v=5, then reset
        run_b(87, 14, 0, 11, 0, -1, 0, 0);
        chk("b_mid_h", int'(hb), 7);
        chk("b_mid_v", int'(vb), 5);
        reset_b = 1'b1;
        @(negedge clk);
        chk("b_mrst_h", int'(hb), 0);
        chk("b_mrst_v", int'(vb), 0);
        chk("b_mrst_hbl", int'(hbl_b), 1);
        chk("b_mrst_vbl", int'(vbl_b), 1);
        chk("b_mrst_hsync", int'(hs_b), 0);
        chk("b_mrst_vsync", int'(vs_b), 0);
        chk("b_mrst_ls", int'(ls_b), 0);
        reset_b = 1'b0;
        hc = 0; vc = 0;
        // Inputs still +1/+1, but cleared latches give nominal syncs again
        run_b(192, 13, 15, 10, 11, -1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
